// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and output decode for the memory-port arbiter
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT   = 3'd1,
    LOAD    = 3'd2,
    ACCESS  = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5,
    ERR     = 3'd6,
    RELEASE = 3'd7
  } arb_state_t;

  localparam logic OWN_IF    = 1'b0;
  localparam logic OWN_EX    = 1'b1;
  localparam logic DIR_READ  = 1'b1;
  localparam logic DIR_WRITE = 1'b0;

  typedef struct packed {
    logic if_gnt;
    logic ex_gnt;
    logic mar_load;
    logic mem_en;
    logic r_w;
    logic mdr_read_en;
    logic if_done;
    logic ex_done;
    logic bus_err;
  } arb_out_t;

  // Outputs are a pure function of (state, owner, dir) so they can be registered
  // together with the state they belong to.
  function automatic arb_out_t decode_outputs(input arb_state_t st, input logic owner,
                                              input logic dir);
    arb_out_t o;
    logic     gnt;
    logic     done;
    o             = '0;
    gnt           = (st != IDLE) && (st != RELEASE);
    done          = (st == DONE) || (st == ERR);
    o.if_gnt      = gnt && (owner == OWN_IF);
    o.ex_gnt      = gnt && (owner == OWN_EX);
    o.mar_load    = (st == LOAD);
    o.mem_en      = (st == ACCESS);
    o.r_w         = (st == ACCESS) && (dir == DIR_READ);
    o.mdr_read_en = (st == CAPTURE);
    o.if_done     = done && (owner == OWN_IF);
    o.ex_done     = done && (owner == OWN_EX);
    o.bus_err     = (st == ERR);
    return o;
  endfunction

endpackage

// File: rtl/mfc_watchdog.sv
// rtl/mfc_watchdog.sv - MFC timeout counter for the ACCESS phase
module mfc_watchdog #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_timeout
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  // Saturates at LAST so a stalled FSM can never wrap the counter back to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_timeout = (r_count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF/EX memory-port arbiter and access sequencer
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ifReq,
  input  logic exReq,
  input  logic exRW,
  input  logic MFC,
  output logic ifGnt,
  output logic exGnt,
  output logic marLoad,
  output logic memEn,
  output logic R_W,
  output logic mdrReadEn,
  output logic ifDone,
  output logic exDone,
  output logic busErr
);

  arb_state_t r_state;
  logic       r_owner;
  logic       r_last_owner;
  logic       r_dir;
  arb_out_t   r_out;

  logic w_win_owner;
  logic w_win_dir;
  logic w_owner_req;
  logic w_wd_clear;
  logic w_wd_enable;
  logic w_timeout;

  // Tie goes to whoever was not granted last; single requester always wins.
  assign w_win_owner = (ifReq && exReq) ? ~r_last_owner : (ifReq ? OWN_IF : OWN_EX);
  assign w_win_dir   = (w_win_owner == OWN_IF) ? DIR_READ : exRW;
  assign w_owner_req = (r_owner == OWN_IF) ? ifReq : exReq;
  assign w_wd_clear  = (r_state == LOAD);
  assign w_wd_enable = (r_state == ACCESS) && !MFC;

  mfc_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_wd_clear),
    .i_enable (w_wd_enable),
    .o_timeout(w_timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_owner      <= OWN_EX;
      r_last_owner <= OWN_EX;
      r_dir        <= DIR_WRITE;
      r_out        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ifReq || exReq) begin
            r_state      <= GRANT;
            r_owner      <= w_win_owner;
            r_last_owner <= w_win_owner;
            r_dir        <= w_win_dir;
            r_out        <= decode_outputs(GRANT, w_win_owner, w_win_dir);
          end
        end
        GRANT: begin
          r_state <= LOAD;
          r_out   <= decode_outputs(LOAD, r_owner, r_dir);
        end
        LOAD: begin
          r_state <= ACCESS;
          r_out   <= decode_outputs(ACCESS, r_owner, r_dir);
        end
        ACCESS: begin
          // MFC takes priority over a timeout landing in the same cycle.
          if (MFC) begin
            if (r_dir == DIR_READ) begin
              r_state <= CAPTURE;
              r_out   <= decode_outputs(CAPTURE, r_owner, r_dir);
            end else begin
              r_state <= DONE;
              r_out   <= decode_outputs(DONE, r_owner, r_dir);
            end
          end else if (w_timeout) begin
            r_state <= ERR;
            r_out   <= decode_outputs(ERR, r_owner, r_dir);
          end
        end
        CAPTURE: begin
          r_state <= DONE;
          r_out   <= decode_outputs(DONE, r_owner, r_dir);
        end
        DONE, ERR: begin
          r_state <= RELEASE;
          r_out   <= decode_outputs(RELEASE, r_owner, r_dir);
        end
        RELEASE: begin
          if (!w_owner_req) begin
            r_state <= IDLE;
            r_out   <= decode_outputs(IDLE, r_owner, r_dir);
          end
        end
        default: begin
          r_state <= IDLE;
          r_out   <= '0;
        end
      endcase
    end
  end

  assign ifGnt     = r_out.if_gnt;
  assign exGnt     = r_out.ex_gnt;
  assign marLoad   = r_out.mar_load;
  assign memEn     = r_out.mem_en;
  assign R_W       = r_out.r_w;
  assign mdrReadEn = r_out.mdr_read_en;
  assign ifDone    = r_out.if_done;
  assign exDone    = r_out.ex_done;
  assign busErr    = r_out.bus_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int TO = 15;

  localparam logic [8:0] B_IFG = 9'h100;
  localparam logic [8:0] B_EXG = 9'h080;
  localparam logic [8:0] B_MAR = 9'h040;
  localparam logic [8:0] B_MEM = 9'h020;
  localparam logic [8:0] B_RW  = 9'h010;
  localparam logic [8:0] B_MDR = 9'h008;
  localparam logic [8:0] B_IFD = 9'h004;
  localparam logic [8:0] B_EXD = 9'h002;
  localparam logic [8:0] B_ERR = 9'h001;

  logic clk = 1'b0;
  logic reset, ifReq, exReq, exRW, MFC;
  logic ifGnt, exGnt, marLoad, memEn, R_W, mdrReadEn, ifDone, exDone, busErr;
  logic [8:0] w_outs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .ifReq(ifReq), .exReq(exReq), .exRW(exRW), .MFC(MFC),
    .ifGnt(ifGnt), .exGnt(exGnt), .marLoad(marLoad), .memEn(memEn), .R_W(R_W),
    .mdrReadEn(mdrReadEn), .ifDone(ifDone), .exDone(exDone), .busErr(busErr)
  );

  assign w_outs = {ifGnt, exGnt, marLoad, memEn, R_W, mdrReadEn, ifDone, exDone, busErr};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    ifReq = 0; exReq = 0; exRW = 0; MFC = 0; reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  // Directed cycle tables: inputs driven in cycle k, outputs expected in cycle k.
  typedef struct { logic if_req; logic ex_req; logic ex_rw; logic mfc; logic [8:0] exp; } vec_t;
  vec_t tbl[$];

  task automatic v(input logic ir, input logic er, input logic rw, input logic m,
                   input logic [8:0] e);
    vec_t t;
    t.if_req = ir; t.ex_req = er; t.ex_rw = rw; t.mfc = m; t.exp = e;
    tbl.push_back(t);
  endtask

  // Reference model: a transaction is a queue of expected output steps.
  typedef struct { logic [8:0] o; logic mfc; logic acc; } step_t;
  step_t mq[$];
  step_t st;
  int    m_phase;
  logic  m_last, m_owner, m_dir;
  int    m_d;
  int    if_cd, ex_cd;
  int    dl[8] = '{0, 1, 2, 5, 13, 14, 15, 30};

  task automatic mpush(input logic [8:0] o, input logic mfc, input logic acc);
    step_t s;
    s.o = o; s.mfc = mfc; s.acc = acc;
    mq.push_back(s);
  endtask

  task automatic build_txn(input logic owner, input logic dir, input int d);
    logic [8:0] g, dn;
    int         n;
    g  = (owner == 1'b0) ? B_IFG : B_EXG;
    dn = (owner == 1'b0) ? B_IFD : B_EXD;
    n  = (d <= TO - 1) ? d + 1 : TO;
    mpush(g, 1'b0, 1'b0);
    mpush(g | B_MAR, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) mpush(g | B_MEM | (dir ? B_RW : 9'h0), (i == d), 1'b1);
    if (d <= TO - 1) begin
      if (dir) mpush(g | B_MDR, 1'b0, 1'b0);
      mpush(g | dn, 1'b0, 1'b0);
    end else begin
      mpush(g | dn | B_ERR, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int   order[$];
    logic p_if, p_ex, found, seen, err_seen;
    int   acc, icd, ecd;

    do_reset();
    chk("reset_outputs", w_outs, 9'h0);

    // IF alone, MFC in first ACCESS cycle
    v(1,0,0,0, 9'h0);            v(1,0,0,0, B_IFG);
    v(1,0,0,0, B_IFG|B_MAR);     v(1,0,0,1, B_IFG|B_MEM|B_RW);
    v(1,0,0,0, B_IFG|B_MDR);     v(0,0,0,0, B_IFG|B_IFD);
    v(0,0,0,0, 9'h0);            v(0,0,0,0, 9'h0);
    // EX write, MFC three cycles late
    v(0,1,0,0, 9'h0);            v(0,1,0,0, B_EXG);
    v(0,1,0,0, B_EXG|B_MAR);     v(0,1,0,0, B_EXG|B_MEM);
    v(0,1,0,0, B_EXG|B_MEM);     v(0,1,0,0, B_EXG|B_MEM);
    v(0,1,0,1, B_EXG|B_MEM);     v(0,0,0,0, B_EXG|B_EXD);
    v(0,0,0,0, 9'h0);            v(0,0,0,0, 9'h0);
    // EX read; exRW toggles and exReq drops mid-transaction, then IF follows
    v(0,1,1,0, 9'h0);            v(0,1,0,0, B_EXG);
    v(0,1,0,0, B_EXG|B_MAR);     v(0,0,0,0, B_EXG|B_MEM|B_RW);
    v(0,0,1,1, B_EXG|B_MEM|B_RW);v(0,0,0,0, B_EXG|B_MDR);
    v(0,0,0,0, B_EXG|B_EXD);     v(0,0,0,0, 9'h0);
    v(1,0,0,0, 9'h0);            v(1,0,0,0, B_IFG);
    v(1,0,0,0, B_IFG|B_MAR);     v(1,0,0,1, B_IFG|B_MEM|B_RW);
    v(1,0,0,0, B_IFG|B_MDR);     v(0,0,0,0, B_IFG|B_IFD);
    v(0,0,0,0, 9'h0);

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      chk($sformatf("vec%0d", k), w_outs, tbl[k].exp);
      ifReq = tbl[k].if_req; exReq = tbl[k].ex_req; exRW = tbl[k].ex_rw; MFC = tbl[k].mfc;
    end

    // Round-robin: every grant is a tie, expect IF, EX, IF, EX
    do_reset();
    ifReq = 1; exReq = 1; exRW = 1;
    p_if = 0; p_ex = 0; icd = 0; ecd = 0;
    for (int c = 0; c < 200 && order.size() < 4; c++) begin
      @(negedge clk);
      if (ifGnt && !p_if) order.push_back(0);
      if (exGnt && !p_ex) order.push_back(1);
      p_if = ifGnt; p_ex = exGnt;
      MFC = memEn;
      if (icd > 0) begin icd--; if (icd == 0) ifReq = 1; end
      if (ecd > 0) begin ecd--; if (ecd == 0) exReq = 1; end
      if (ifDone) begin ifReq = 0; icd = 2; end
      if (exDone) begin exReq = 0; ecd = 2; end
    end
    chk("tie_grant_count", order.size(), 4);
    for (int i = 0; i < order.size(); i++) chk($sformatf("tie_order%0d", i), order[i], i % 2);

    // Watchdog: EX read with MFC stuck low
    do_reset();
    exReq = 1; exRW = 1;
    acc = 0; seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (memEn) acc++;
      if (exDone) begin
        seen = 1;
        chk("to_err_cycle", w_outs, B_EXG | B_EXD | B_ERR);
      end
    end
    chk("to_done_seen", seen, 1);
    chk("to_access_cycles", acc, TO);
    exReq = 0; ifReq = 1;
    seen = 0; err_seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      MFC = memEn;
      if (busErr) err_seen = 1;
      if (ifDone) seen = 1;
    end
    chk("to_next_done", seen, 1);
    chk("to_next_no_err", err_seen, 0);
    ifReq = 0; MFC = 0;

    // Asynchronous reset in the middle of an IF ACCESS
    do_reset();
    ifReq = 1; found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (memEn) found = 1;
    end
    chk("rst_reach_access", found, 1);
    #2 reset = 1;
    #1 chk("rst_async_outputs", w_outs, 9'h0);
    exReq = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_held_outputs", w_outs, 9'h0);
    reset = 0;
    @(negedge clk);
    chk("rst_first_tie_if", w_outs, B_IFG);

    // Randomized traffic against the transaction-queue model
    do_reset();
    m_phase = 0; m_last = 1'b1; m_owner = 1'b0; if_cd = 0; ex_cd = 0;
    mq.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (m_phase == 1) st = mq.pop_front();
      else begin st.o = '0; st.mfc = 0; st.acc = 0; end
      chk($sformatf("rand_cyc%0d", cyc), w_outs, st.o);
      MFC = st.acc ? st.mfc : ($urandom_range(0, 3) == 0);
      if (if_cd > 0) if_cd--;
      else if (!ifReq && $urandom_range(0, 2) == 0) ifReq = 1;
      if ((st.o & B_IFD) != 0) begin ifReq = 0; if_cd = $urandom_range(1, 3); end
      if (ex_cd > 0) ex_cd--;
      else if (!exReq && $urandom_range(0, 2) == 0) exReq = 1;
      exRW = $urandom_range(0, 1);
      if ((st.o & B_EXD) != 0) begin exReq = 0; ex_cd = $urandom_range(1, 3); end
      if (m_phase == 1) begin
        if (mq.size() == 0) m_phase = 2;
      end else if (m_phase == 2) begin
        if (!((m_owner == 1'b0) ? ifReq : exReq)) m_phase = 0;
      end else if (ifReq || exReq) begin
        m_owner = (ifReq && exReq) ? !m_last : (ifReq ? 1'b0 : 1'b1);
        m_last  = m_owner;
        m_dir   = (m_owner == 1'b0) ? 1'b1 : exRW;
        m_d     = dl[$urandom_range(0, 7)];
        build_txn(m_owner, m_dir, m_d);
        m_phase = 1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single memory port (MAR, memory, MDR read path) between the instruction-fetch requester (IF) and the execute-stage load/store requester (EX). Grants bus ownership to one requester at a time. Sequences marLoad, memEn/R_W, the MFC handshake and mdrReadEn on the requester's behalf, and returns a one-cycle done pulse. A watchdog aborts accesses whose MFC never arrives.

## Interface
- TIMEOUT_CYCLES, 15: max cycles in ACCESS without MFC before abort (≥2)
- CNT_W, 4: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- ifReq  in  1  IF requests a memory read; held until ifDone
- exReq  in  1  EX requests a memory access; held until exDone
- exRW  in  1  EX direction: 1 = read, 0 = write (same sense as R_W)
- MFC  in  1  memory function complete
- ifGnt  out  1  IF owns the bus; IF drives the address (pcOutEn) while high
- exGnt  out  1  EX owns the bus; EX drives the address/MDR while high
- marLoad  out  1  load MAR from bus
- memEn  out  1  memory enable
- R_W  out  1  1 = read, 0 = write; valid while memEn = 1, else 0
- mdrReadEn  out  1  capture memory data into MDR (reads only)
- ifDone, exDone  out  1  one-cycle completion pulse to the owning requester
- busErr  out  1  one-cycle pulse on MFC timeout

## Operation
- Moore FSM. All outputs are registered decodes of the current state plus the owner flag.
- States:
  - IDLE: no grant, all outputs 0. If any req → GRANT.
  - GRANT: gnt of owner = 1; address settles on bus → LOAD.
  - LOAD: gnt, marLoad = 1 → ACCESS.
  - ACCESS: gnt, memEn = 1, R_W = dir. MFC = 1 → CAPTURE if dir = read, else DONE. Count reaches TIMEOUT_CYCLES−1 with MFC = 0 → ERR.
  - CAPTURE: gnt, mdrReadEn = 1, memEn = 0 → DONE.
  - DONE: gnt, owner done = 1 → RELEASE.
  - ERR: gnt, owner done = 1, busErr = 1 → RELEASE.
  - RELEASE: gnt = 0. Wait until the owner req = 0, then → IDLE.
- Arbitration in IDLE only:
  - Single requester wins.
  - On a tie, the requester not granted last wins (round-robin).
  - lastOwner resets to EX, so IF wins the first tie.
- dir is latched at grant: IF → read; EX → exRW. Later exRW changes are ignored.
- Once granted, the transaction runs to DONE/ERR. A req drop mid-transaction is ignored.
- The non-owner's req is held pending, never lost. It is evaluated on return to IDLE.
- Watchdog counter clears on ACCESS entry and increments each ACCESS cycle with MFC = 0. If MFC and timeout coincide, MFC wins.

## Timing
- Reset: state = IDLE, lastOwner = EX, counter = 0, every output 0. Reset mid-transaction drops memEn/gnt immediately (async). No done pulse is issued.
- Read, MFC in first ACCESS cycle, with req at IDLE in cycle 0:
  - GRANT cycle 1, LOAD 2, ACCESS 3, CAPTURE 4, DONE 5, RELEASE 6.
  - IDLE at cycle 7 at the earliest.
- Write: same sequence without CAPTURE (DONE at cycle 4).
- Each extra ACCESS cycle without MFC adds one cycle.
- Minimum grant-to-grant spacing between back-to-back transactions: 2 cycles (RELEASE, IDLE).
- ifGnt and exGnt are never high together. Neither is high in RELEASE or IDLE (one bus-clearing cycle).

## Structure
- Package mem_arb_pkg:
  - state enumeration (IDLE, GRANT, LOAD, ACCESS, CAPTURE, DONE, ERR, RELEASE; 3-bit)
  - requester IDs OWN_IF = 0, OWN_EX = 1
  - DIR_READ = 1, DIR_WRITE = 0
- One sub-module, mfc_watchdog: a CNT_W-bit counter with clear/enable inputs and a timeout output. It is instantiated once.

## Test plan
- IF alone: ifReq = 1 from cycle 0, MFC = 1 in cycle 3 → marLoad cycle 2, memEn/R_W = 1 cycle 3, mdrReadEn cycle 4, ifDone cycle 5, ifGnt high cycles 1–5.
- EX write, exRW = 0, MFC delayed 3 cycles → memEn high cycles 3–6, R_W = 0, no mdrReadEn, exDone in the cycle after MFC.
- Tie after reset: ifReq = exReq = 1 → IF granted first, EX granted second; next tie → IF again (alternation verified over 4 transactions).
- Timeout: EX read with MFC stuck 0, TIMEOUT_CYCLES = 15 → 15 ACCESS cycles, then busErr and exDone pulse together, memEn = 0; next request proceeds normally.
- Reset asserted during ACCESS → all outputs 0 asynchronously, no done pulse; after release, the first tie grants IF.
- exReq dropped during ACCESS and exRW toggled mid-transaction → transaction completes with the latched direction; FSM returns to IDLE without waiting in RELEASE.
